// File: rtl/uart_link_pkg.sv
// Shared definitions for the UART transmit path: FSM encodings, timing defaults
// and the saturating drop counter helper.
package uart_link_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DONE = 2'd1,
        ST_GAP       = 2'd2
    } tx_state_e;

    localparam int unsigned GAP_DEFAULT     = 32;
    localparam int unsigned TIMEOUT_DEFAULT = 1024;
    localparam logic [7:0]  DROP_MAX        = 8'hFF;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == DROP_MAX) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// DEPTH x 8 synchronous FIFO with single-cycle flush; count is one bit wider
// than the pointers so full and empty are distinct.
module byte_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [7:0]        din,
    output logic [7:0]        head,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; pointers and count alone decide
    // which entries are valid, so clearing the data would only cost flops.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Selects the manual or script byte source, queues accepted bytes and hands
// them to the UART one at a time with a done handshake, gap and watchdog.
module uart_tx_arbiter
    import uart_link_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned GAP     = GAP_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              sel_script,
    input  logic              hold,
    input  logic [7:0]        man_bits,
    input  logic              man_valid,
    output logic              man_ready,
    input  logic [7:0]        scr_bits,
    input  logic              scr_valid,
    output logic              scr_ready,
    output logic [7:0]        tx_bits,
    output logic              tx_valid,
    input  logic              tx_done,
    output logic [ADDR_W:0]   fifo_count,
    output logic [7:0]        drop_cnt,
    output logic              err_timeout,
    input  logic              clr_err
);

    localparam int unsigned WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned GC_W = (GAP > 2) ? $clog2(GAP) : 1;
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [GC_W-1:0] GAP_LAST = GC_W'(GAP - 1);

    tx_state_e         state;
    logic [WD_W-1:0]   wd;
    logic [GC_W-1:0]   gap_cnt;
    logic              sel_q;
    logic              out_en;
    logic              flush;
    logic              active_valid;
    logic [7:0]        active_bits;
    logic              active_ready;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [7:0]        head;

    // out_en keeps both readies low while reset is asserted and until the
    // first clock after release.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            sel_q  <= 1'b0;
            out_en <= 1'b0;
        end else begin
            sel_q  <= sel_script;
            out_en <= 1'b1;
        end
    end

    assign flush = sel_script ^ sel_q;

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        active_valid = man_valid;
        active_bits  = man_bits;
        if (sel_script) begin
            active_valid = scr_valid;
            active_bits  = scr_bits;
        end
    end

    assign active_ready = out_en & ~full & ~flush;
    assign man_ready    = active_ready & ~sel_script;
    assign scr_ready    = active_ready &  sel_script;
    assign push         = active_valid & active_ready;
    assign pop          = (state == ST_IDLE) & ~empty & ~hold & ~flush;

    byte_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .res_n (res_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (active_bits),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state       <= ST_IDLE;
            tx_bits     <= 8'h00;
            tx_valid    <= 1'b0;
            wd          <= '0;
            gap_cnt     <= '0;
            drop_cnt    <= 8'd0;
            err_timeout <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments; when clr_err and a drop land in
            // the same cycle, the later drop assignment below takes effect.
            if (clr_err) begin
                drop_cnt    <= 8'd0;
                err_timeout <= 1'b0;
            end

            unique case (state)
                ST_IDLE: begin
                    if (pop) begin
                        tx_bits  <= head;
                        tx_valid <= 1'b1;
                        wd       <= '0;
                        state    <= ST_WAIT_DONE;
                    end
                end

                ST_WAIT_DONE: begin
                    if (tx_done) begin
                        tx_valid <= 1'b0;
                        gap_cnt  <= '0;
                        state    <= ST_GAP;
                    end else if (wd == WD_LAST) begin
                        tx_valid    <= 1'b0;
                        gap_cnt     <= '0;
                        err_timeout <= 1'b1;
                        drop_cnt    <= clr_err ? 8'd1 : sat_inc8(drop_cnt);
                        state       <= ST_GAP;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) state <= ST_IDLE;
                    else                     gap_cnt <= gap_cnt + 1'b1;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a queue-based reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_uart_tx_arbiter;

    localparam int DEPTH   = 8;
    localparam int ADDR_W  = 3;
    localparam int GAP     = 32;
    // Shortened watchdog keeps the 256-drop saturation run brief; still longer
    // than the 160-cycle byte time used by the manual scenario.
    localparam int TIMEOUT = 192;

    logic              clk = 1'b0;
    logic              res_n = 1'b0;
    logic              sel_script = 1'b0;
    logic              hold = 1'b0;
    logic [7:0]        man_bits = 8'h00;
    logic              man_valid = 1'b0;
    logic              man_ready;
    logic [7:0]        scr_bits = 8'h00;
    logic              scr_valid = 1'b0;
    logic              scr_ready;
    logic [7:0]        tx_bits;
    logic              tx_valid;
    logic              tx_done = 1'b0;
    logic [ADDR_W:0]   fifo_count;
    logic [7:0]        drop_cnt;
    logic              err_timeout;
    logic              clr_err = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .GAP     (GAP),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .res_n       (res_n),
        .sel_script  (sel_script),
        .hold        (hold),
        .man_bits    (man_bits),
        .man_valid   (man_valid),
        .man_ready   (man_ready),
        .scr_bits    (scr_bits),
        .scr_valid   (scr_valid),
        .scr_ready   (scr_ready),
        .tx_bits     (tx_bits),
        .tx_valid    (tx_valid),
        .tx_done     (tx_done),
        .fifo_count  (fifo_count),
        .drop_cnt    (drop_cnt),
        .err_timeout (err_timeout),
        .clr_err     (clr_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue, the byte on the wire, and plain counters
    // for how long it has waited and how much quiet time remains.
    logic [7:0] m_q[$];
    logic       m_sel_prev;
    logic       m_en;
    logic       m_show;
    logic [7:0] m_byte;
    int         m_wait;
    int         m_gap;
    int         m_drops;
    logic       m_err;

    always @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            m_q.delete();
            m_sel_prev = 1'b0;
            m_en       = 1'b0;
            m_show     = 1'b0;
            m_byte     = 8'h00;
            m_wait     = 0;
            m_gap      = 0;
            m_drops    = 0;
            m_err      = 1'b0;
        end else begin
            logic fl;
            logic rdy;
            logic drop;
            fl   = (sel_script != m_sel_prev);
            rdy  = m_en && !fl && (m_q.size() < DEPTH);
            drop = 1'b0;
            if (m_show) begin
                if (tx_done) begin
                    m_show = 1'b0;
                    m_gap  = GAP;
                end else if (m_wait == TIMEOUT - 1) begin
                    m_show = 1'b0;
                    m_gap  = GAP;
                    drop   = 1'b1;
                end else begin
                    m_wait++;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (m_q.size() > 0 && !hold && !fl) begin
                m_byte = m_q.pop_front();
                m_show = 1'b1;
                m_wait = 0;
            end
            if (fl) m_q.delete();
            if (rdy && (sel_script ? scr_valid : man_valid))
                m_q.push_back(sel_script ? scr_bits : man_bits);
            if (clr_err) begin
                m_drops = 0;
                m_err   = 1'b0;
            end
            if (drop) begin
                m_err   = 1'b1;
                m_drops = (m_drops >= 255) ? 255 : m_drops + 1;
            end
            m_sel_prev = sel_script;
            m_en       = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (res_n) begin
            logic er;
            er = m_en && (sel_script == m_sel_prev) && (m_q.size() < DEPTH);
            check("model_tx", {tx_valid, tx_valid ? tx_bits : 8'h00},
                  {m_show, m_show ? m_byte : 8'h00});
            check("model_count", 32'(fifo_count), 32'(m_q.size()));
            check("model_ready", {man_ready, scr_ready}, {er & ~sel_script, er & sel_script});
            check("model_err", {err_timeout, drop_cnt}, {m_err, 8'(m_drops)});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max_cycles);
        int n = 0;
        while (!tx_valid && n < max_cycles) begin
            tick(1);
            n++;
        end
        if (!tx_valid) check("wait_tx_valid", tx_valid, 1);
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
    endtask

    task automatic push_man(input logic [7:0] b);
        man_bits  = b;
        man_valid = 1'b1;
        tick(1);
        man_valid = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        int n;
        int drops;
        int prev;

        // Reset values
        #2;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_bits", tx_bits, 8'h00);
        check("rst_count", fifo_count, 0);
        check("rst_readies", {man_ready, scr_ready}, 2'b00);
        check("rst_err", {err_timeout, drop_cnt}, 9'h000);
        @(negedge clk);
        res_n = 1'b1;
        tick(2);

        // Manual single byte: no bypass, visible two edges after the push
        push_man(8'h25);
        check("no_bypass", tx_valid, 0);
        tick(1);
        check("single_valid", tx_valid, 1);
        check("single_bits", tx_bits, 8'h25);
        push_man(8'h26);
        tick(157);
        check("single_held", {tx_valid, tx_bits}, 9'h125);
        pulse_done();
        check("single_fall", tx_valid, 0);
        n = 0;
        while (!tx_valid && n < 200) begin
            tick(1);
            n++;
        end
        check("gap_len", n, GAP + 1);
        check("second_bits", tx_bits, 8'h26);
        tick(10);
        pulse_done();

        // Source isolation and the single flush cycle
        scr_bits  = 8'h77;
        scr_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            check("iso_scr_ready", scr_ready, 0);
            tick(1);
        end
        check("iso_count", fifo_count, 0);
        sel_script = 1'b1;
        #1;
        check("flush_ready", scr_ready, 0);
        tick(1);
        check("after_flush_ready", scr_ready, 1);
        scr_valid = 1'b0;
        tick(40);

        // Fill and back-pressure, then ordered drain with a hold in WAIT_DONE
        sel_script = 1'b0;
        tick(2);
        hold = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            man_bits  = 8'(i);
            man_valid = 1'b1;
            check("fill_ready", man_ready, 1);
            tick(1);
        end
        man_bits = 8'h09;
        check("full_ready", man_ready, 0);
        check("full_count", fifo_count, 8);
        tick(3);
        check("full_hold_count", fifo_count, 8);
        man_valid = 1'b0;
        hold = 1'b0;
        for (int k = 0; k < 8; k++) begin
            wait_valid(100);
            check("drain_order", tx_bits, k + 1);
            tick(5);
            if (k == 3) hold = 1'b1;
            pulse_done();
            if (k == 3) begin
                tick(GAP + 10);
                check("hold_blocks", tx_valid, 0);
                hold = 1'b0;
            end
        end
        tick(GAP + 5);

        // Flush mid-stream
        hold = 1'b1;
        for (int i = 0; i < 5; i++) push_man(8'h31 + 8'(i));
        hold = 1'b0;
        wait_valid(20);
        check("flush_first", tx_bits, 8'h31);
        check("flush_pre_count", fifo_count, 4);
        sel_script = 1'b1;
        tick(1);
        check("flush_count", fifo_count, 0);
        check("flush_inflight", {tx_valid, tx_bits}, 9'h131);
        tick(10);
        pulse_done();
        check("flush_done", tx_valid, 0);
        n = 0;
        for (int i = 0; i < GAP + 60; i++) begin
            if (tx_valid) n++;
            tick(1);
        end
        check("flush_no_more", n, 0);

        // Timeout, done-beats-timeout, drop-beats-clear
        sel_script = 1'b0;
        tick(2);
        push_man(8'hA3);
        wait_valid(10);
        n = 0;
        while (tx_valid && n < TIMEOUT + 10) begin
            tick(1);
            n++;
        end
        check("timeout_len", n, TIMEOUT);
        check("timeout_err", {err_timeout, drop_cnt}, 9'h101);
        tick(GAP + 5);
        push_man(8'hB4);
        wait_valid(10);
        tick(TIMEOUT - 1);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        check("done_wins", {tx_valid, err_timeout, drop_cnt}, 10'h101);
        tick(GAP + 5);
        push_man(8'hC5);
        wait_valid(10);
        tick(TIMEOUT - 1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("drop_beats_clr", {err_timeout, drop_cnt}, 9'h101);
        tick(GAP + 5);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("clr_err", {err_timeout, drop_cnt}, 9'h000);

        // Saturation of drop_cnt
        man_bits  = 8'hA3;
        man_valid = 1'b1;
        drops = 0;
        n = 0;
        prev = tx_valid;
        while (drops < 257 && n < 70000) begin
            tick(1);
            n++;
            if (prev == 1 && !tx_valid) drops++;
            prev = tx_valid;
        end
        check("sat_drops_seen", drops, 257);
        check("sat_cnt", drop_cnt, 8'hFF);
        man_valid = 1'b0;
        sel_script = 1'b1;
        tick(1);
        sel_script = 1'b0;
        tick(TIMEOUT + GAP + 5);
        check("sat_hold", {err_timeout, drop_cnt}, 9'h1FF);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("sat_clr", {err_timeout, drop_cnt}, 9'h000);

        // Asynchronous reset in WAIT_DONE
        hold = 1'b1;
        push_man(8'h5A);
        push_man(8'h5B);
        push_man(8'h5C);
        hold = 1'b0;
        wait_valid(10);
        tick(20);
        check("pre_reset", {tx_valid, tx_bits, fifo_count}, {1'b1, 8'h5A, 4'd2});
        #2;
        res_n = 1'b0;
        #1;
        check("async_valid", tx_valid, 0);
        check("async_count", fifo_count, 0);
        check("async_bits", tx_bits, 8'h00);
        @(negedge clk);
        res_n = 1'b1;
        tick(3);
        pulse_done();
        check("late_done", {tx_valid, err_timeout, drop_cnt}, 10'h000);
        tick(GAP + 5);
        check("post_reset_idle", {tx_valid, fifo_count}, 5'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
